// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator-CPU controller:
// FSM states and the 3-bit opcode set.
package cpu_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_OP_ADDR    = 4'd3,
    S_OP_FETCH   = 4'd4,
    S_ALU_OP     = 4'd5,
    S_STORE      = 4'd6,
    S_NEXT       = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  function automatic logic loads_ac(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctrl_retire_cnt.sv
// Retired-instruction counter: wraps from all-ones to zero,
// cleared by synchronous active-low reset.
module ctrl_retire_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_controller_p.sv
// Multi-cycle controller for a simple accumulator CPU:
// opcode decode, sequencing FSM and datapath strobes.
module cpu_controller_p
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int WAIT_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               go,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instr_count
);

  state_e     state_q;
  state_e     state_d;
  state_e     cur_s;
  logic       ready;
  logic       ill;
  logic [2:0] op3;
  logic       is_hlt;
  logic       is_skz;
  logic       is_sto;
  logic       is_jmp;
  logic       is_acc;

  generate
    if (OPC_W > 3) begin : g_ill
      assign ill = |opcode[OPC_W-1:3];
    end else begin : g_noill
      assign ill = 1'b0;
    end
  endgenerate

  assign op3    = opcode[2:0];
  assign ready  = (WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign is_hlt = !ill && (op3 == OP_HLT);
  assign is_skz = !ill && (op3 == OP_SKZ);
  assign is_sto = !ill && (op3 == OP_STO);
  assign is_jmp = !ill && (op3 == OP_JMP);
  assign is_acc = !ill && loads_ac(op3);

  // Outputs see INST_ADDR while reset is held low.
  assign cur_s = rst ? state_q : S_INST_ADDR;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_INST_ADDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INST_ADDR:  state_d = S_INST_FETCH;
      S_INST_FETCH: if (ready) state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = S_OP_FETCH;
      S_OP_FETCH:   if (ready) state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      if (!(is_sto && !ready)) state_d = S_NEXT;
      S_NEXT:       state_d = is_hlt ? S_HALTED : S_INST_ADDR;
      S_HALTED:     if (go) state_d = S_INST_ADDR;
      default:      state_d = S_INST_ADDR;
    endcase
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (cur_s)
      S_INST_ADDR:  sel = 1'b1;
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_ADDR:  ;
      S_OP_FETCH: rd = 1'b1;
      S_ALU_OP: begin
        ld_pc  = is_jmp;
        inc_pc = is_skz && zero;
      end
      S_STORE: begin
        ld_ac  = is_acc;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_NEXT: begin
        data_e = is_sto;
        inc_pc = !(is_jmp || is_hlt);
      end
      S_HALTED: begin
        halt   = 1'b1;
        inc_pc = go;
      end
      default: ;
    endcase
  end

  assign illegal_op = ill;
  assign state      = cur_s;

  ctrl_retire_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == S_NEXT),
    .cnt_o (instr_count)
  );

endmodule

// File: tb/tb_cpu_controller_p.sv
// Randomized bench for cpu_controller_p against an
// instruction-level schedule model.
module tb_cpu_controller_p;

  localparam int CW = 4;

  typedef struct {
    int   st;
    logic mr;
    logic g;
  } cyc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          go;
  logic          sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic          halt, illegal_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  logic          n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_ac, n_ld_pc;
  logic          n_wr, n_data_e, n_halt, n_ill;
  logic [3:0]    n_state;
  logic [15:0]   n_cnt;

  int errors = 0;
  int checks = 0;
  int mcount = 0;

  always #5 clk = ~clk;

  cpu_controller_p #(
    .OPC_W(4), .WAIT_EN(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .go(go),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
    .halt(halt), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  cpu_controller_p #(
    .OPC_W(3), .WAIT_EN(0), .CNT_W(16)
  ) u_nw (
    .clk(clk), .rst(rst), .opcode(opcode[2:0]), .zero(zero),
    .mem_ready(1'b0), .go(go),
    .sel(n_sel), .rd(n_rd), .ld_ir(n_ld_ir), .inc_pc(n_inc_pc),
    .ld_ac(n_ld_ac), .ld_pc(n_ld_pc), .wr(n_wr), .data_e(n_data_e),
    .halt(n_halt), .illegal_op(n_ill), .state(n_state),
    .instr_count(n_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_strb(input int st,
                                          input logic [3:0] op,
                                          input logic z,
                                          input logic g);
    logic [2:0] o;
    bit lg, s, r, ir, inc, ac, pc, w, de, h;
    o   = op[2:0];
    lg  = !op[3];
    s   = (st <= 2);
    r   = (st == 1) || (st == 2) || (st == 4);
    ir  = (st == 2);
    inc = (st == 5 && lg && o == 3'd1 && z) ||
          (st == 7 && !(lg && (o == 3'd7 || o == 3'd0))) ||
          (st == 8 && g);
    ac  = (st == 6) && lg && (o >= 3'd2) && (o <= 3'd5);
    pc  = (st == 5) && lg && (o == 3'd7);
    w   = (st == 6) && lg && (o == 3'd6);
    de  = (st == 6 || st == 7) && lg && (o == 3'd6);
    h   = (st == 8);
    return {s, r, ir, inc, ac, pc, w, de, h};
  endfunction

  function automatic logic [8:0] dut_strb();
    return {sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e, halt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the cycle schedule of one instruction, then plays it.
  task automatic run_instr(input logic [3:0] op, input logic z,
                           input int w1f, input int hold,
                           input bit exit_go);
    cyc_t q[$];
    int w1, w2, w3, h;
    bit sto, hlt;
    w1  = (w1f < 0) ? int'($urandom_range(0, 3)) : w1f;
    w2  = $urandom_range(0, 3);
    w3  = $urandom_range(0, 3);
    h   = (hold < 0) ? int'($urandom_range(0, 5)) : hold;
    sto = !op[3] && (op[2:0] == 3'd6);
    hlt = !op[3] && (op[2:0] == 3'd0);
    q.push_back('{0, rb(), rb()});
    for (int i = 0; i < w1; i++) q.push_back('{1, 1'b0, rb()});
    q.push_back('{1, 1'b1, rb()});
    q.push_back('{2, rb(), rb()});
    q.push_back('{3, rb(), rb()});
    for (int i = 0; i < w2; i++) q.push_back('{4, 1'b0, rb()});
    q.push_back('{4, 1'b1, rb()});
    q.push_back('{5, rb(), rb()});
    if (sto) begin
      for (int i = 0; i < w3; i++) q.push_back('{6, 1'b0, rb()});
      q.push_back('{6, 1'b1, rb()});
    end else begin
      q.push_back('{6, rb(), rb()});
    end
    q.push_back('{7, rb(), rb()});
    if (hlt) begin
      for (int i = 0; i < h; i++) q.push_back('{8, rb(), 1'b0});
      if (exit_go) q.push_back('{8, rb(), 1'b1});
    end
    opcode = op;
    zero   = z;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      go        = q[i].g;
      @(negedge clk);
      chk("state", 32'(state), 32'(q[i].st));
      chk("strobes", 32'(dut_strb()),
          32'(exp_strb(q[i].st, op, z, q[i].g)));
      chk("illegal_op", 32'(illegal_op), 32'(op[3]));
      chk("instr_count", 32'(instr_count), 32'(mcount % (1 << CW)));
      if (q[i].st == 7) mcount++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    opcode    = 4'h2;
    zero      = 1'b0;
    mem_ready = 1'b0;
    go        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(dut_strb()), 32'h100);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b1;

    // No-wait instance ignores mem_ready: ADD takes exactly 8 cycles.
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("nw_state", 32'(n_state), 32'(i));
      chk("nw_ld_ac", 32'(n_ld_ac), 32'(i == 6));
      chk("nw_inc_pc", 32'(n_inc_pc), 32'(i == 7));
      chk("add_state", 32'(state), 32'(i));
      @(posedge clk);
      #1;
    end
    chk("nw_count", 32'(n_cnt), 32'd1);
    chk("add_count", 32'(instr_count), 32'd1);
    mcount = 1;

    run_instr(4'h2, 1'b0, 3, 0, 1'b1);
    run_instr(4'h1, 1'b1, -1, 0, 1'b1);
    run_instr(4'h1, 1'b0, -1, 0, 1'b1);
    run_instr(4'h7, 1'b1, -1, 0, 1'b1);
    run_instr(4'h0, 1'b0, -1, 20, 1'b1);
    run_instr(4'hE, 1'b1, -1, 0, 1'b1);
    run_instr(4'h6, 1'b0, -1, 0, 1'b1);
    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom_range(0, 15)), rb(), -1, -1, 1'b1);

    // Reset while waiting in OP_FETCH.
    opcode    = 4'h2;
    mem_ready = 1'b1;
    go        = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("opf_wait_state", 32'(state), 32'd4);
    rst = 1'b0;
    @(negedge clk);
    chk("opf_rst_strobes", 32'(dut_strb()), 32'h100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("opf_rst_state", 32'(state), 32'd0);
    chk("opf_rst_count", 32'(instr_count), 32'd0);
    mcount = 0;

    // Reset while HALTED.
    run_instr(4'h0, 1'b0, -1, 3, 1'b0);
    @(negedge clk);
    chk("halted_state", 32'(state), 32'd8);
    chk("halted_halt", 32'(halt), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("hlt_rst_strobes", 32'(dut_strb()), 32'h100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("hlt_rst_state", 32'(state), 32'd0);
    chk("hlt_rst_halt", 32'(halt), 32'd0);
    chk("hlt_rst_count", 32'(instr_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
